rc4_stream_xor: RTL
===================

# rc4_stream_xor

Keystream consumer for the RC4 generator. It pulls keystream bytes from the RC4 core over a valid/ready handshake and buffers them in a small FIFO. It XORs each buffered byte with one incoming data byte to produce the output stream, so the same block encrypts and decrypts. It sits between the RC4 core's keystream output and the byte-wide data path, and processes one message of `msg_len` bytes per `start`.

## Interface
- `KS_DEPTH`, default 4: keystream FIFO depth in bytes; must be a power of 2 and at least 2.
- `LEN_W`, default 16: width of the message length and byte counters.
- `clk` input 1: single clock; all logic is on the rising edge.
- `rst` input 1: synchronous, active-high reset.
- `start` input 1: begin a message; sampled only in IDLE.
- `msg_len` input LEN_W: message byte count; latched when `start` is accepted.
- `ks_valid` input 1: keystream byte available from the RC4 core.
- `ks_data` input 8: keystream byte.
- `ks_ready` output 1: FIFO accepts a keystream byte this cycle.
- `din_valid` input 1: data byte available.
- `din` input 8: plaintext or ciphertext byte.
- `din_ready` output 1: the block consumes `din` this cycle.
- `dout_valid` output 1: output byte valid.
- `dout` output 8: `din ^ keystream`.
- `dout_last` output 1: qualifies the final byte of the message.
- `dout_ready` input 1: downstream accepts `dout`.
- `busy` output 1: high in every state except IDLE.
- `done` output 1: one-cycle pulse when the message completes.

## Operation
- States: IDLE, RUN, DRAIN, DONE.
- IDLE, on `start`:
  - Latch `msg_len` into `len_q`.
  - Clear `ks_cnt` (bytes fetched), `tx_cnt` (bytes XORed) and the FIFO.
  - Go to RUN if `msg_len`≠0, else go to DONE.
- `start` outside IDLE is ignored.
- Keystream fetch: `ks_ready` = RUN & !fifo_full & (`ks_cnt` < `len_q`).
  - A push occurs on `ks_valid & ks_ready`; `ks_cnt` increments.
  - No keystream beyond `len_q` bytes is ever requested.
- XOR: `din_ready` = RUN & !fifo_empty & (!`dout_valid` | `dout_ready`).
- On `din_valid & din_ready`:
  - `dout` <= `din ^ fifo_head`; the FIFO pops.
  - `dout_valid` <= 1; `tx_cnt` increments.
  - `dout_last` <= (`tx_cnt` == `len_q`-1).
- When the last byte is consumed, go to DRAIN.
- Output register: when `dout_valid & dout_ready` and no new byte is loaded the same cycle, `dout_valid` <= 0.
- DRAIN: once `dout_valid` & `dout_ready` (last byte accepted), go to DONE.
- DONE: `done`=1 for one cycle, then IDLE.
- FIFO: KS_DEPTH entries with log2(KS_DEPTH)+1-bit read/write pointers.
  - Full when the MSBs differ and the remaining bits are equal.
  - Empty when the pointers are equal.
  - Pointers wrap modulo 2·KS_DEPTH.
- Boundaries:
  - FIFO full with a pop in the same cycle: the push is still blocked, because `ks_ready` uses the registered full flag.
  - FIFO empty: `din_ready`=0 even if `din_valid`.
  - `msg_len`=0: no handshakes occur; `done` pulses 2 cycles after `start`.
  - `msg_len`=2^LEN_W-1 must work; counters never overflow.
- `rst` at any time: all state returns to IDLE and the FIFO is flushed; no `done` pulse is produced.

## Timing
- Reset values:
  - `ks_ready`, `din_ready`, `dout_valid`, `dout_last`, `busy`, `done` = 0.
  - `dout` = 8'h00; state IDLE.
- `start` accepted at edge N: `busy`=1 and `ks_ready` may be 1 from cycle N+1.
- A keystream byte pushed at edge M is usable by `din` at edge M+1 (no FIFO bypass).
- `din` accepted at edge K: `dout`/`dout_valid` are visible after edge K, i.e. 1-cycle latency.
- Steady-state throughput is 1 byte/cycle with `ks_valid`, `din_valid` and `dout_ready` all held high.
- Final output byte accepted at edge L: state DONE after L; `done`=1 during cycle L+1; IDLE at L+2.
- `dout`, `dout_last` hold stable while `dout_valid & !dout_ready`.

## Test plan
- **Known vector:** keystream EB 9F 77 81 B7 34 CA 72 A7 (RC4 key "Key"); `din` "Plaintext" 50 6C 61 69 6E 74 65 78 74; `msg_len`=9.
  - `dout` = BB F3 16 E8 D9 40 AF 0A D3.
  - `dout_last` only on D3; exactly one `done` pulse.
- **Decrypt round trip:** feed BB..D3 with the same keystream.
  - `dout` = 50 6C ... 74.
- **Backpressure:** same vector, `dout_ready` low for 3 cycles mid-stream; `ks_valid` toggled randomly.
  - Output bytes are unchanged and in order.
  - `ks_ready` drops when 4 bytes are buffered.
  - Exactly 9 keystream handshakes occur.
- **`msg_len`=0:** `start` gives `done` 2 cycles later; `ks_ready`, `din_ready`, `dout_valid` stay 0.
- **Reset mid-message:** `rst` asserted after 4 of 9 bytes.
  - Next cycle all outputs are at reset values and there is no `done`.
  - A new 9-byte run then produces the correct full vector.
- **Start while busy:** a second `start` pulse with `msg_len`=1 during RUN is ignored; the original 9 bytes complete.

Source files
------------

// File: rtl/rc4_stream_xor.sv
// rc4_stream_xor: buffers RC4 keystream bytes in a small FIFO and XORs each one with an
// incoming data byte, one msg_len-byte message per start.
module rc4_stream_xor #(
  parameter int unsigned KS_DEPTH = 4,
  parameter int unsigned LEN_W    = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [LEN_W-1:0] msg_len,
  input  logic             ks_valid,
  input  logic [7:0]       ks_data,
  output logic             ks_ready,
  input  logic             din_valid,
  input  logic [7:0]       din,
  output logic             din_ready,
  output logic             dout_valid,
  output logic [7:0]       dout,
  output logic             dout_last,
  input  logic             dout_ready,
  output logic             busy,
  output logic             done
);

  localparam int unsigned AddrW = $clog2(KS_DEPTH);
  localparam int unsigned PtrW  = AddrW + 1;
  localparam logic [LEN_W-1:0] LenOne = LEN_W'(1);
  localparam logic [PtrW-1:0]  PtrOne = PtrW'(1);

  typedef enum logic [1:0] {StIdle, StRun, StDrain, StDone} state_e;

  state_e state_q, state_d;

  logic [LEN_W-1:0] len_q, ks_cnt_q, tx_cnt_q;
  logic [PtrW-1:0]  wr_ptr_q, rd_ptr_q;
  logic [7:0]       mem_q [KS_DEPTH];
  logic [7:0]       dout_q;
  logic             dout_valid_q, dout_last_q;

  logic fifo_full, fifo_empty, push, pop, last_pop, accept_start, in_run;

  // Pointers carry one extra wrap bit so full and empty are distinguishable.
  assign fifo_full  = (wr_ptr_q[PtrW-1] != rd_ptr_q[PtrW-1]) &&
                      (wr_ptr_q[AddrW-1:0] == rd_ptr_q[AddrW-1:0]);
  assign fifo_empty = (wr_ptr_q == rd_ptr_q);

  assign in_run    = (state_q == StRun);
  assign ks_ready  = in_run && !fifo_full && (ks_cnt_q < len_q);
  assign din_ready = in_run && !fifo_empty && (!dout_valid_q || dout_ready);
  assign push      = ks_valid && ks_ready;
  assign pop       = din_valid && din_ready;
  assign last_pop  = pop && (tx_cnt_q == len_q - LenOne);

  assign dout_valid = dout_valid_q;
  assign dout       = dout_q;
  assign dout_last  = dout_last_q;

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= StIdle;
    end else begin
      state_q <= state_d;
    end
  end

  always_comb begin
    state_d      = state_q;
    busy         = 1'b1;
    done         = 1'b0;
    accept_start = 1'b0;
    case (state_q)
      StIdle: begin
        busy = 1'b0;
        if (start) begin
          accept_start = 1'b1;
          state_d      = (msg_len != '0) ? StRun : StDone;
        end
      end
      StRun: begin
        if (last_pop) begin
          state_d = StDrain;
        end
      end
      StDrain: begin
        if (dout_valid_q && dout_ready) begin
          state_d = StDone;
        end
      end
      StDone: begin
        done    = 1'b1;
        state_d = StIdle;
      end
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      len_q        <= '0;
      ks_cnt_q     <= '0;
      tx_cnt_q     <= '0;
      wr_ptr_q     <= '0;
      rd_ptr_q     <= '0;
      dout_q       <= '0;
      dout_valid_q <= 1'b0;
      dout_last_q  <= 1'b0;
    end else if (accept_start) begin
      len_q       <= msg_len;
      ks_cnt_q    <= '0;
      tx_cnt_q    <= '0;
      wr_ptr_q    <= '0;
      rd_ptr_q    <= '0;
      dout_last_q <= 1'b0;
    end else begin
      if (push) begin
        wr_ptr_q <= wr_ptr_q + PtrOne;
        ks_cnt_q <= ks_cnt_q + LenOne;
      end
      if (pop) begin
        rd_ptr_q     <= rd_ptr_q + PtrOne;
        tx_cnt_q     <= tx_cnt_q + LenOne;
        dout_q       <= din ^ mem_q[rd_ptr_q[AddrW-1:0]];
        dout_valid_q <= 1'b1;
        dout_last_q  <= (tx_cnt_q == len_q - LenOne);
      end else if (dout_valid_q && dout_ready) begin
        dout_valid_q <= 1'b0;
      end
    end
  end

  // Storage needs no reset: emptiness is tracked by the pointers alone.
  always_ff @(posedge clk) begin
    if (push) begin
      mem_q[wr_ptr_q[AddrW-1:0]] <= ks_data;
    end
  end

endmodule
